// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a small receive FIFO
// with a CPU pop handshake, sticky error flags and a CPU-written LED register.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int LED_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_in,
  output logic [DATA_BITS-1:0]          uart_to_cpu_buf,
  output logic                          read_int,
  input  logic                          cpu_end_read,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clr,
  input  logic [LED_W-1:0]              leds_array,
  input  logic                          write_leds,
  output logic [LED_W-1:0]              leds
);

  localparam int CW  = $clog2(CLK_DIV);
  localparam int IW  = $clog2(DATA_BITS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = AW + 1;
  localparam logic [CW-1:0] HALF_BIT = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic          ODD_PAR  = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;

  logic                 r_rx_meta, r_rx_s, r_rx_prev;
  logic                 r_end_read_d, r_write_leds_d;
  state_t               r_state, w_state_next;
  logic [CW-1:0]        r_cnt, w_cnt_next;
  logic [IW-1:0]        r_idx, w_idx_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_par_bad, w_par_bad_next;
  logic                 w_push_next, w_set_frame, w_set_par, w_tick;
  logic                 r_push;
  logic [DATA_BITS-1:0] r_push_data;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [NW-1:0]        r_count;
  logic                 r_read_int;
  logic [DATA_BITS-1:0] r_buf;
  logic                 r_frame_err, r_parity_err, r_overrun;
  logic [LED_W-1:0]     r_leds;
  logic                 w_pop, w_full, w_write, w_drop;

  // Two-flop synchronizer for the serial line, previous-value regs for edge detects
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta      <= 1'b1;
      r_rx_s         <= 1'b1;
      r_rx_prev      <= 1'b1;
      r_end_read_d   <= 1'b0;
      r_write_leds_d <= 1'b0;
    end else begin
      r_rx_meta      <= uart_in;
      r_rx_s         <= r_rx_meta;
      r_rx_prev      <= r_rx_s;
      r_end_read_d   <= cpu_end_read;
      r_write_leds_d <= write_leds;
    end
  end

  assign w_tick = (r_cnt == '0);

  // Receiver FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_par_bad   <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_idx       <= w_idx_next;
      r_shift     <= w_shift_next;
      r_par_bad   <= w_par_bad_next;
      r_push      <= w_push_next;
      r_push_data <= r_shift;
    end
  end

  // Receiver next-state: half-bit wait to mid start, then one sample per bit period
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_idx_next     = r_idx;
    w_shift_next   = r_shift;
    w_par_bad_next = r_par_bad;
    w_push_next    = 1'b0;
    w_set_frame    = 1'b0;
    w_set_par      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rx_prev && !r_rx_s) begin
          w_state_next   = S_START;
          w_cnt_next     = HALF_BIT;
          w_par_bad_next = 1'b0;
        end
      end
      S_START: begin
        if (!w_tick) begin
          w_cnt_next = r_cnt - CW'(1);
        end else if (r_rx_s) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DATA;
          w_cnt_next   = FULL_BIT;
          w_idx_next   = '0;
        end
      end
      S_DATA: begin
        if (!w_tick) begin
          w_cnt_next = r_cnt - CW'(1);
        end else begin
          // LSB arrives first, so shifting right leaves it at bit 0 after the last bit
          w_shift_next = {r_rx_s, r_shift[DATA_BITS-1:1]};
          w_cnt_next   = FULL_BIT;
          w_idx_next   = r_idx + IW'(1);
          if (r_idx == LAST_IDX) begin
            w_state_next = (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
      end
      S_PAR: begin
        if (!w_tick) begin
          w_cnt_next = r_cnt - CW'(1);
        end else begin
          w_cnt_next   = FULL_BIT;
          w_state_next = S_STOP;
          if ((^{r_shift, r_rx_s}) != ODD_PAR) begin
            w_par_bad_next = 1'b1;
            w_set_par      = 1'b1;
          end
        end
      end
      S_STOP: begin
        if (!w_tick) begin
          w_cnt_next = r_cnt - CW'(1);
        end else if (r_rx_s) begin
          w_state_next = S_IDLE;
          w_push_next  = !r_par_bad;
        end else begin
          w_state_next = S_BREAK;
          w_set_frame  = 1'b1;
        end
      end
      S_BREAK: begin
        if (r_rx_s) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_full  = (r_count == NW'(FIFO_DEPTH));
  assign w_pop   = cpu_end_read && !r_end_read_d && (r_count != '0);
  // A pop in the same cycle frees the slot, so a push at full still lands
  assign w_write = r_push && (!w_full || w_pop);
  assign w_drop  = r_push && w_full && !w_pop;

  // FIFO storage, written without reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= r_push_data;
    end
  end

  // FIFO pointers, occupancy, registered head/interrupt, sticky flags and LEDs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_read_int   <= 1'b0;
      r_buf        <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_leds       <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
      r_read_int <= (r_count != '0);
      r_buf      <= (r_count != '0) ? r_mem[r_rd_ptr] : '0;
      r_frame_err  <= w_set_frame || (r_frame_err  && !err_clr);
      r_parity_err <= w_set_par   || (r_parity_err && !err_clr);
      r_overrun    <= w_drop      || (r_overrun    && !err_clr);
      if (write_leds && !r_write_leds_d) r_leds <= leds_array;
    end
  end

  assign uart_to_cpu_buf = r_buf;
  assign read_int        = r_read_int;
  assign fifo_count      = r_count;
  assign frame_err       = r_frame_err;
  assign parity_err      = r_parity_err;
  assign overrun         = r_overrun;
  assign leds            = r_leds;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one 8N1 instance and one 8E1 instance.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx0, rx1;
  logic       end0, end1;
  logic       err_clr0, err_clr1;
  logic [7:0] leds_array;
  logic       write_leds;

  logic [7:0] buf0, buf1, leds0, leds1;
  logic       rint0, rint1;
  logic [2:0] cnt0, cnt1;
  logic       ferr0, ferr1, perr0, perr1, ovr0, ovr1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4), .LED_W(8)) dut (
    .clk(clk), .reset(reset), .uart_in(rx0),
    .uart_to_cpu_buf(buf0), .read_int(rint0), .cpu_end_read(end0),
    .fifo_count(cnt0), .frame_err(ferr0), .parity_err(perr0), .overrun(ovr0),
    .err_clr(err_clr0), .leds_array(leds_array), .write_leds(write_leds), .leds(leds0)
  );

  uart_rx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(4), .LED_W(8)) dut_par (
    .clk(clk), .reset(reset), .uart_in(rx1),
    .uart_to_cpu_buf(buf1), .read_int(rint1), .cpu_end_read(end1),
    .fifo_count(cnt1), .frame_err(ferr1), .parity_err(perr1), .overrun(ovr1),
    .err_clr(err_clr1), .leds_array(leds_array), .write_leds(write_leds), .leds(leds1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int sel, input logic v, input int nclk);
    if (sel == 0) rx0 = v; else rx1 = v;
    wait_clks(nclk);
  endtask

  // Called on a negedge; start bit, 8 data bits LSB first, optional parity,
  // optional extra low time on the stop bit, then a 16-clk high stop bit.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                            input logic pbit, input int stop_low_clks);
    drive_bit(sel, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], 16);
    if (has_par) drive_bit(sel, pbit, 16);
    if (stop_low_clks > 0) drive_bit(sel, 1'b0, stop_low_clks);
    drive_bit(sel, 1'b1, 16);
    wait_clks(4);
  endtask

  task automatic pop0();
    end0 = 1'b1;
    wait_clks(1);
    end0 = 1'b0;
    wait_clks(3);
  endtask

  task automatic clr0();
    err_clr0 = 1'b1;
    wait_clks(1);
    err_clr0 = 1'b0;
    wait_clks(2);
  endtask

  logic [7:0] exp_q [4];

  initial begin
    reset = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
    end0 = 1'b0; end1 = 1'b0; err_clr0 = 1'b0; err_clr1 = 1'b0;
    leds_array = 8'h00; write_leds = 1'b0;
    wait_clks(5);

    // reset state
    chk("rst_buf", buf0, 8'h00);
    chk("rst_rint", rint0, 1'b0);
    chk("rst_cnt", cnt0, 3'd0);
    chk("rst_flags", {ferr0, perr0, ovr0}, 3'b000);
    chk("rst_leds", leds0, 8'h00);
    reset = 1'b0;
    wait_clks(3);
    chk("rst_cnt_after", cnt0, 3'd0);
    chk("rst_rint_after", rint0, 1'b0);

    // 1: single 8N1 byte, then pop
    send_frame(0, 8'hA5, 0, 1'b0, 0);
    chk("t1_rint", rint0, 1'b1);
    chk("t1_buf", buf0, 8'hA5);
    chk("t1_cnt", cnt0, 3'd1);
    pop0();
    chk("t1_rint_pop", rint0, 1'b0);
    chk("t1_cnt_pop", cnt0, 3'd0);

    // 2: short low glitch is rejected, receiver still works afterwards
    drive_bit(0, 1'b0, 4);
    drive_bit(0, 1'b1, 40);
    chk("t2_cnt", cnt0, 3'd0);
    chk("t2_flags", {ferr0, perr0, ovr0}, 3'b000);
    send_frame(0, 8'h5C, 0, 1'b0, 0);
    chk("t2_next_buf", buf0, 8'h5C);
    pop0();

    // 3: five bytes into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 0, 1'b0, 0);
    chk("t3_cnt", cnt0, 3'd4);
    chk("t3_head", buf0, 8'h01);
    chk("t3_ovr", ovr0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t3_pop%0d", i), buf0, 32'(i));
      pop0();
    end
    chk("t3_cnt_empty", cnt0, 3'd0);
    pop0();
    chk("t3_pop_empty_cnt", cnt0, 3'd0);
    clr0();
    chk("t3_ovr_clr", ovr0, 1'b0);

    // 4: even parity; 0x07 has three ones so parity bit must be 1
    send_frame(1, 8'h07, 1, 1'b0, 0);
    chk("t4_perr", perr1, 1'b1);
    chk("t4_cnt_bad", cnt1, 3'd0);
    chk("t4_ferr", ferr1, 1'b0);
    send_frame(1, 8'h07, 1, 1'b1, 0);
    chk("t4_cnt_good", cnt1, 3'd1);
    chk("t4_buf_good", buf1, 8'h07);

    // 5: stop bit held low for three bit times
    send_frame(0, 8'h11, 0, 1'b0, 48);
    chk("t5_ferr", ferr0, 1'b1);
    chk("t5_cnt", cnt0, 3'd0);
    wait_clks(32);
    send_frame(0, 8'h3C, 0, 1'b0, 0);
    chk("t5_cnt_next", cnt0, 3'd1);
    chk("t5_buf_next", buf0, 8'h3C);
    pop0();
    clr0();
    chk("t5_ferr_clr", ferr0, 1'b0);

    // 6a: reset in the middle of a frame's data bits
    send_frame(0, 8'h66, 0, 1'b0, 0);
    chk("t6_cnt_pre", cnt0, 3'd1);
    drive_bit(0, 1'b0, 16);
    drive_bit(0, 1'b1, 16);
    drive_bit(0, 1'b0, 16);
    reset = 1'b1;
    rx0 = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(200);
    chk("t6_cnt_rst", cnt0, 3'd0);
    chk("t6_rint_rst", rint0, 1'b0);

    // 6b: LED register
    leds_array = 8'h5A;
    write_leds = 1'b1;
    wait_clks(1);
    write_leds = 1'b0;
    wait_clks(2);
    chk("t6_leds", leds0, 8'h5A);
    leds_array = 8'hFF;
    wait_clks(3);
    chk("t6_leds_hold", leds0, 8'h5A);

    // 6c: push and pop in the same cycle with the FIFO full
    exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
    send_frame(0, 8'h11, 0, 1'b0, 0);
    for (int i = 0; i < 3; i++) send_frame(0, exp_q[i], 0, 1'b0, 0);
    chk("t6_full_cnt", cnt0, 3'd4);
    fork
      send_frame(0, 8'h55, 0, 1'b0, 0);
      begin
        // push lands on the clock after negedge 155 of the frame
        wait_clks(155);
        end0 = 1'b1;
        wait_clks(1);
        end0 = 1'b0;
      end
    join
    chk("t6_pp_cnt", cnt0, 3'd4);
    chk("t6_pp_ovr", ovr0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_pp_pop%0d", i), buf0, 32'(exp_q[i]));
      pop0();
    end
    chk("t6_pp_empty", cnt0, 3'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
